// File: rtl/train_pkg.sv
// Shared encodings and decode tables for the FP/BP/WG training phase sequencer.
package train_pkg;

  localparam int unsigned ST_W     = 3;
  localparam int unsigned PE_SEL_W = 6;
  localparam int unsigned MODE_W   = 2;
  localparam int unsigned OMODE_W  = 3;
  localparam int unsigned CUT_W    = 2;

  localparam logic [ST_W-1:0] ST_IDLE = 3'd0;
  localparam logic [ST_W-1:0] ST_FP   = 3'd1;
  localparam logic [ST_W-1:0] ST_BP   = 3'd2;
  localparam logic [ST_W-1:0] ST_WG   = 3'd3;
  localparam logic [ST_W-1:0] ST_CLR  = 3'd4;
  localparam logic [ST_W-1:0] ST_DONE = 3'd5;

  // PE mux selects, bit order {m0,m1,m2,m3,s0,s1}
  localparam logic [PE_SEL_W-1:0] PE_SEL_IDLE  = 6'b100000;
  localparam logic [PE_SEL_W-1:0] PE_SEL_FP_S0 = 6'b100010;
  localparam logic [PE_SEL_W-1:0] PE_SEL_FP_S1 = 6'b010010;
  localparam logic [PE_SEL_W-1:0] PE_SEL_BP_S0 = 6'b100010;
  localparam logic [PE_SEL_W-1:0] PE_SEL_BP_S1 = 6'b100000;
  localparam logic [PE_SEL_W-1:0] PE_SEL_WG_S0 = 6'b101111;
  localparam logic [PE_SEL_W-1:0] PE_SEL_WG_S1 = 6'b011111;

  localparam logic [MODE_W-1:0] INPREF_MODE_IDLE  = 2'b01;
  localparam logic [MODE_W-1:0] INPREF_MODE_FP_S0 = 2'b01;
  localparam logic [MODE_W-1:0] INPREF_MODE_FP_S1 = 2'b00;
  localparam logic [MODE_W-1:0] INPREF_MODE_BP    = 2'b11;
  localparam logic [MODE_W-1:0] INPREF_MODE_WG_S0 = 2'b01;
  localparam logic [MODE_W-1:0] INPREF_MODE_WG_S1 = 2'b00;

  localparam logic [OMODE_W-1:0] INPREF_OMODE_IDLE  = 3'b000;
  localparam logic [OMODE_W-1:0] INPREF_OMODE_FP_S0 = 3'b000;
  localparam logic [OMODE_W-1:0] INPREF_OMODE_FP_S1 = 3'b010;
  localparam logic [OMODE_W-1:0] INPREF_OMODE_BP_S0 = 3'b000;
  localparam logic [OMODE_W-1:0] INPREF_OMODE_BP_S1 = 3'b100;
  localparam logic [OMODE_W-1:0] INPREF_OMODE_WG_S0 = 3'b001;
  localparam logic [OMODE_W-1:0] INPREF_OMODE_WG_S1 = 3'b010;

  // Cutting enables, bit order {cut1,cut0}
  localparam logic [CUT_W-1:0] CUT_IDLE  = 2'b00;
  localparam logic [CUT_W-1:0] CUT_FP    = 2'b01;
  localparam logic [CUT_W-1:0] CUT_BP_S0 = 2'b00;
  localparam logic [CUT_W-1:0] CUT_BP_S1 = 2'b10;
  localparam logic [CUT_W-1:0] CUT_WG    = 2'b00;

  typedef struct packed {
    logic [PE_SEL_W-1:0] pe_sel;
    logic [MODE_W-1:0]   inpref_mode;
    logic [OMODE_W-1:0]  inpref_omode;
    logic [CUT_W-1:0]    en_cutting;
  } dec_t;

  // Datapath decode for a run phase at a given stride; non-phase codes get the idle decode.
  function automatic dec_t phase_decode(input logic [ST_W-1:0] ph, input logic s);
    dec_t d;
    d.pe_sel       = PE_SEL_IDLE;
    d.inpref_mode  = INPREF_MODE_IDLE;
    d.inpref_omode = INPREF_OMODE_IDLE;
    d.en_cutting   = CUT_IDLE;
    case (ph)
      ST_FP: begin
        d.pe_sel       = s ? PE_SEL_FP_S1 : PE_SEL_FP_S0;
        d.inpref_mode  = s ? INPREF_MODE_FP_S1 : INPREF_MODE_FP_S0;
        d.inpref_omode = s ? INPREF_OMODE_FP_S1 : INPREF_OMODE_FP_S0;
        d.en_cutting   = CUT_FP;
      end
      ST_BP: begin
        d.pe_sel       = s ? PE_SEL_BP_S1 : PE_SEL_BP_S0;
        d.inpref_mode  = INPREF_MODE_BP;
        d.inpref_omode = s ? INPREF_OMODE_BP_S1 : INPREF_OMODE_BP_S0;
        d.en_cutting   = s ? CUT_BP_S1 : CUT_BP_S0;
      end
      ST_WG: begin
        d.pe_sel       = s ? PE_SEL_WG_S1 : PE_SEL_WG_S0;
        d.inpref_mode  = s ? INPREF_MODE_WG_S1 : INPREF_MODE_WG_S0;
        d.inpref_omode = s ? INPREF_OMODE_WG_S1 : INPREF_OMODE_WG_S0;
        d.en_cutting   = CUT_WG;
      end
      default: ;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/phase_cnt.sv
// Wrapping up-counter: counts enabled cycles 0..last, then returns to 0; clear has priority.
module phase_cnt #(
  parameter int unsigned W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] last,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: clear, wrap at terminal value, or increment when enabled
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = (cnt_q == last) ? '0 : cnt_q + W'(1);
    end
  end

  // Count register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/train_phase_seq.sv
// Layer-by-layer FP -> BP -> WG sequencer for the systolic training datapath, with PE clear windows.
module train_phase_seq
  import train_pkg::*;
#(
  parameter int unsigned CW      = 5,
  parameter int unsigned LW      = 4,
  parameter int unsigned RST_CYC = 1,
  parameter int unsigned GROUP   = 5,
  parameter int unsigned FP_SKIP = 4,
  parameter int unsigned WG_SKIP = 3
) (
  input  logic          clk,
  input  logic          fsm_rst,
  input  logic          start,
  input  logic          stride2,
  input  logic [LW-1:0] num_layers,
  input  logic [CW-1:0] fp_len,
  input  logic [CW-1:0] bp_len,
  input  logic [CW-1:0] wg_len,
  input  logic          stall,
  output logic [2:0]    state,
  output logic          in_en,
  output logic          pe_clr,
  output logic [5:0]    pe_sel,
  output logic [1:0]    en_cutting,
  output logic [1:0]    inpref_mode,
  output logic [2:0]    inpref_omode,
  output logic          buf_in_sel,
  output logic          buf_out_sel,
  output logic          sa_en,
  output logic          busy,
  output logic          done,
  output logic [LW-1:0] layer_idx
);

  logic [ST_W-1:0] state_q, state_d;
  logic [ST_W-1:0] ret_q, ret_d;
  logic [LW-1:0]   layer_q, layer_d;
  logic [LW-1:0]   nl_q, nl_d;
  logic            parity_q, parity_d;
  logic            stride_q, stride_d;
  logic [CW-1:0]   fp_len_q, fp_len_d;
  logic [CW-1:0]   bp_len_q, bp_len_d;
  logic [CW-1:0]   wg_len_q, wg_len_d;

  logic            run_c;
  logic            in_en_c;
  logic            phase_enter_c;
  logic            cnt_en_c;
  logic            cnt_clr_c;
  logic            cnt_at_last_c;
  logic [CW-1:0]   cnt_last_c;
  logic [CW-1:0]   cur_len_c;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   sub;
  logic [LW-1:0]   nl_last_c;
  logic [ST_W-1:0] dec_ph_c;
  logic            sa_gate_c;
  dec_t            dec_c;

  assign run_c     = (state_q == ST_FP) || (state_q == ST_BP) || (state_q == ST_WG);
  assign in_en_c   = run_c && !stall;
  assign nl_last_c = nl_q - LW'(1);

  // Phase counter terminal value: run length in FP/BP/WG, clear window length in CLR
  always_comb begin
    cur_len_c = CW'(1);
    case (state_q)
      ST_FP:   cur_len_c = fp_len_q;
      ST_BP:   cur_len_c = bp_len_q;
      ST_WG:   cur_len_c = wg_len_q;
      default: cur_len_c = CW'(1);
    endcase
    cnt_last_c = (state_q == ST_CLR) ? CW'(RST_CYC - 1) : cur_len_c - CW'(1);
  end

  assign cnt_en_c      = in_en_c || (state_q == ST_CLR);
  assign cnt_clr_c     = (state_q == ST_IDLE);
  assign cnt_at_last_c = (cnt == cnt_last_c);

  phase_cnt #(.W(CW)) u_phase_cnt (
    .clk  (clk),
    .rst  (fsm_rst),
    .en   (cnt_en_c),
    .clr  (cnt_clr_c),
    .last (cnt_last_c),
    .cnt  (cnt)
  );

  // Sub-counter restarts with each phase so the sa_en gating pattern is phase-aligned
  phase_cnt #(.W(CW)) u_sub_cnt (
    .clk  (clk),
    .rst  (fsm_rst),
    .en   (in_en_c),
    .clr  (phase_enter_c),
    .last (CW'(GROUP - 1)),
    .cnt  (sub)
  );

  // Next-state, config latch, layer and parity update
  always_comb begin
    state_d       = state_q;
    ret_d         = ret_q;
    layer_d       = layer_q;
    nl_d          = nl_q;
    parity_d      = parity_q;
    stride_d      = stride_q;
    fp_len_d      = fp_len_q;
    bp_len_d      = bp_len_q;
    wg_len_d      = wg_len_q;
    phase_enter_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          stride_d      = stride2;
          nl_d          = (num_layers == '0) ? LW'(1) : num_layers;
          fp_len_d      = (fp_len == '0) ? CW'(1) : fp_len;
          bp_len_d      = (bp_len == '0) ? CW'(1) : bp_len;
          wg_len_d      = (wg_len == '0) ? CW'(1) : wg_len;
          layer_d       = '0;
          state_d       = ST_FP;
          phase_enter_c = 1'b1;
        end
      end
      ST_FP, ST_BP, ST_WG: begin
        if (in_en_c) begin
          if (stride_q) begin
            parity_d = ~parity_q;
          end
          if (cnt_at_last_c) begin
            state_d = ST_CLR;
            case (state_q)
              ST_FP:   ret_d = ST_BP;
              ST_BP:   ret_d = ST_WG;
              default: ret_d = (layer_q == nl_last_c) ? ST_DONE : ST_FP;
            endcase
          end
        end
      end
      ST_CLR: begin
        if (cnt_at_last_c) begin
          state_d = ret_q;
          if (ret_q == ST_FP) begin
            layer_d = layer_q + LW'(1);
          end
          if (ret_q != ST_DONE) begin
            phase_enter_c = 1'b1;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (phase_enter_c) begin
      parity_d = 1'b0;
    end
  end

  // State and configuration registers
  always_ff @(posedge clk or posedge fsm_rst) begin
    if (fsm_rst) begin
      state_q  <= ST_IDLE;
      ret_q    <= ST_IDLE;
      layer_q  <= '0;
      nl_q     <= '0;
      parity_q <= 1'b0;
      stride_q <= 1'b0;
      fp_len_q <= '0;
      bp_len_q <= '0;
      wg_len_q <= '0;
    end else begin
      state_q  <= state_d;
      ret_q    <= ret_d;
      layer_q  <= layer_d;
      nl_q     <= nl_d;
      parity_q <= parity_d;
      stride_q <= stride_d;
      fp_len_q <= fp_len_d;
      bp_len_q <= bp_len_d;
      wg_len_q <= wg_len_d;
    end
  end

  // Datapath decode; CLR keeps the decode of the phase that just finished
  always_comb begin
    dec_ph_c = state_q;
    if (state_q == ST_CLR) begin
      case (ret_q)
        ST_BP:   dec_ph_c = ST_FP;
        ST_WG:   dec_ph_c = ST_BP;
        default: dec_ph_c = ST_WG;
      endcase
    end
    dec_c     = phase_decode(dec_ph_c, stride_q);
    sa_gate_c = stride_q && parity_q &&
                (((state_q == ST_FP) && (sub == CW'(FP_SKIP))) ||
                 ((state_q == ST_WG) && (sub == CW'(WG_SKIP))));
  end

  assign state        = state_q;
  assign in_en        = in_en_c;
  assign pe_clr       = (state_q == ST_CLR);
  assign pe_sel       = dec_c.pe_sel;
  assign en_cutting   = dec_c.en_cutting;
  assign inpref_mode  = dec_c.inpref_mode;
  assign inpref_omode = dec_c.inpref_omode;
  assign buf_in_sel   = (state_q == ST_WG);
  assign buf_out_sel  = (state_q == ST_BP);
  assign sa_en        = !sa_gate_c;
  assign busy         = (state_q != ST_IDLE);
  assign done         = (state_q == ST_DONE);
  assign layer_idx    = layer_q;

endmodule

// File: tb/tb_train_phase_seq.sv
// Scoreboard bench for train_phase_seq: driver queues the expected per-cycle output trace, monitor checks it.
module tb_train_phase_seq;

  localparam int unsigned CW = 5;
  localparam int unsigned LW = 4;
  localparam int RST_CYC = 1;

  logic          clk;
  logic          fsm_rst;
  logic          start;
  logic          stride2;
  logic [LW-1:0] num_layers;
  logic [CW-1:0] fp_len;
  logic [CW-1:0] bp_len;
  logic [CW-1:0] wg_len;
  logic          stall;
  logic [2:0]    state;
  logic          in_en;
  logic          pe_clr;
  logic [5:0]    pe_sel;
  logic [1:0]    en_cutting;
  logic [1:0]    inpref_mode;
  logic [2:0]    inpref_omode;
  logic          buf_in_sel;
  logic          buf_out_sel;
  logic          sa_en;
  logic          busy;
  logic          done;
  logic [LW-1:0] layer_idx;

  typedef struct packed {
    logic [2:0]    st;
    logic          ien;
    logic          clr;
    logic [5:0]    pe;
    logic [1:0]    cut;
    logic [1:0]    mode;
    logic [2:0]    omode;
    logic          bin;
    logic          bout;
    logic          sa;
    logic          bsy;
    logic          dn;
    logic [LW-1:0] lay;
  } rec_t;

  rec_t exp_q[$];
  logic stall_q[$];
  int   total;
  int   bad;
  int   gen_n;
  int   mon_idx;

  train_phase_seq dut (
    .clk          (clk),
    .fsm_rst      (fsm_rst),
    .start        (start),
    .stride2      (stride2),
    .num_layers   (num_layers),
    .fp_len       (fp_len),
    .bp_len       (bp_len),
    .wg_len       (wg_len),
    .stall        (stall),
    .state        (state),
    .in_en        (in_en),
    .pe_clr       (pe_clr),
    .pe_sel       (pe_sel),
    .en_cutting   (en_cutting),
    .inpref_mode  (inpref_mode),
    .inpref_omode (inpref_omode),
    .buf_in_sel   (buf_in_sel),
    .buf_out_sel  (buf_out_sel),
    .sa_en        (sa_en),
    .busy         (busy),
    .done         (done),
    .layer_idx    (layer_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic rec_t act_rec();
    rec_t r;
    r.st = state; r.ien = in_en; r.clr = pe_clr; r.pe = pe_sel; r.cut = en_cutting;
    r.mode = inpref_mode; r.omode = inpref_omode; r.bin = buf_in_sel; r.bout = buf_out_sel;
    r.sa = sa_en; r.bsy = busy; r.dn = done; r.lay = layer_idx;
    return r;
  endfunction

  // Hand-written decode table: phase 1=FP 2=BP 3=WG, anything else idle decode
  function automatic rec_t dec_rec(input int ph, input logic s);
    rec_t r;
    r = '0;
    r.sa = 1'b1;
    case (ph)
      1: {r.pe, r.mode, r.omode, r.cut} = s ? {6'b010010, 2'b00, 3'b010, 2'b01}
                                            : {6'b100010, 2'b01, 3'b000, 2'b01};
      2: {r.pe, r.mode, r.omode, r.cut} = s ? {6'b100000, 2'b11, 3'b100, 2'b10}
                                            : {6'b100010, 2'b11, 3'b000, 2'b00};
      3: {r.pe, r.mode, r.omode, r.cut} = s ? {6'b011111, 2'b00, 3'b010, 2'b00}
                                            : {6'b101111, 2'b01, 3'b001, 2'b00};
      default: {r.pe, r.mode, r.omode, r.cut} = {6'b100000, 2'b01, 3'b000, 2'b00};
    endcase
    return r;
  endfunction

  function automatic rec_t idle_rec();
    return dec_rec(0, 1'b0);
  endfunction

  task automatic cmp_rec(input string nm, input rec_t act, input rec_t exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic cmp_int(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic push_rec(input rec_t r, input logic stl, input int max_n);
    if (gen_n < max_n) begin
      exp_q.push_back(r);
      stall_q.push_back(stl);
    end
    gen_n++;
  endtask

  // Expected trace of one run; optional stall burst in layer-0 BP before in_en cycle st_at
  task automatic gen(input logic s, input int nl, input int fl, input int bl, input int wl,
                     input int st_at, input int st_n, input int max_n);
    int nle;
    int len;
    rec_t r;
    nle = (nl == 0) ? 1 : nl;
    gen_n = 0;
    stall_q.delete();
    for (int l = 0; l < nle; l++) begin
      for (int ph = 1; ph <= 3; ph++) begin
        len = (ph == 1) ? fl : (ph == 2) ? bl : wl;
        if (len == 0) len = 1;
        for (int k = 0; k < len; k++) begin
          r = dec_rec(ph, s);
          r.st = 3'(ph); r.bsy = 1'b1; r.lay = LW'(l);
          r.bout = (ph == 2); r.bin = (ph == 3);
          if (s && (k % 2 == 1) && (((ph == 1) && (k % 5 == 4)) || ((ph == 3) && (k % 5 == 3))))
            r.sa = 1'b0;
          if ((ph == 2) && (l == 0) && (k == st_at)) begin
            r.ien = 1'b0;
            for (int j = 0; j < st_n; j++) push_rec(r, 1'b1, max_n);
          end
          r.ien = 1'b1;
          push_rec(r, 1'b0, max_n);
        end
        for (int c = 0; c < RST_CYC; c++) begin
          r = dec_rec(ph, s);
          r.st = 3'd4; r.clr = 1'b1; r.bsy = 1'b1; r.lay = LW'(l);
          push_rec(r, 1'b0, max_n);
        end
      end
    end
    r = idle_rec();
    r.st = 3'd5; r.bsy = 1'b1; r.dn = 1'b1; r.lay = LW'(nle - 1);
    push_rec(r, 1'b0, max_n);
  endtask

  // Start a run and walk its trace; start is re-asserted with junk config on trace cycles sb_from..sb_to
  task automatic run(input string nm, input logic s, input int nl, input int fl, input int bl,
                     input int wl, input int st_at, input int st_n, input int max_n,
                     input int sb_from, input int sb_to);
    int n;
    gen(s, nl, fl, bl, wl, st_at, st_n, max_n);
    n = stall_q.size();
    mon_idx = 0;
    @(posedge clk); #1;
    stride2 = s; num_layers = LW'(nl); fp_len = CW'(fl); bp_len = CW'(bl); wg_len = CW'(wl);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int t = 0; t < n; t++) begin
      stall = stall_q[t];
      if (t >= sb_from && t <= sb_to) begin
        start = 1'b1; stride2 = ~s; num_layers = 4'd5;
        fp_len = 5'd3; bp_len = 5'd2; wg_len = 5'd1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
    end
    stall = 1'b0;
    start = 1'b0;
    if (max_n >= gen_n) begin
      cmp_int({nm, "_drain"}, exp_q.size(), 0);
      cmp_int({nm, "_end_busy"}, int'(busy), 0);
      @(posedge clk); #1;
      cmp_int({nm, "_stay_idle"}, int'(busy), 0);
    end
  endtask

  // Monitor: every busy cycle is an output beat checked against the queue head
  initial begin
    forever begin
      @(negedge clk);
      if (!fsm_rst && busy) begin
        if (exp_q.size() == 0) begin
          cmp_int("unexpected_busy_cycle", 1, 0);
        end else begin
          cmp_rec($sformatf("trace[%0d]", mon_idx), act_rec(), exp_q.pop_front());
        end
        mon_idx++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    total = 0; bad = 0; gen_n = 0; mon_idx = 0;
    fsm_rst = 1'b1; start = 1'b0; stride2 = 1'b0; num_layers = '0;
    fp_len = '0; bp_len = '0; wg_len = '0; stall = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    cmp_rec("reset_outputs", act_rec(), idle_rec());
    fsm_rst = 1'b0;
    @(posedge clk); #1;
    cmp_rec("idle_no_start", act_rec(), idle_rec());

    run("basic", 1'b0, 1, 8, 6, 8, -1, 0, 1000, -1, -1);
    run("stride2", 1'b1, 1, 10, 6, 14, -1, 0, 1000, -1, -1);
    run("layers3", 1'b0, 3, 3, 2, 4, -1, 0, 1000, -1, -1);
    run("stall_bp", 1'b0, 2, 8, 6, 8, 2, 3, 1000, -1, -1);

    // Abort during WG (trace cycle 20 is WG in_en cycle 4)
    run("abort", 1'b0, 1, 8, 6, 8, -1, 0, 20, -1, -1);
    fsm_rst = 1'b1;
    #1;
    cmp_rec("abort_idle_same_cycle", act_rec(), idle_rec());
    cmp_int("abort_drain", exp_q.size(), 0);
    @(posedge clk); #1;
    fsm_rst = 1'b0;
    @(posedge clk); #1;
    cmp_rec("after_abort_idle", act_rec(), idle_rec());
    run("restart", 1'b0, 1, 8, 6, 8, -1, 0, 1000, -1, -1);

    // Zero length/layers, start held while busy and through DONE
    run("zero_cfg", 1'b1, 0, 0, 2, 3, -1, 0, 1000, 0, 999);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
